clk_div_bank: RTL and testbench
===============================

// Module: clk_div_bank
// PURPOSE
//  Generates the 8 divided clocks that feed the 8:1 clock select mux (o_clk_div[k] drives mux input k).
//  Each channel divides i_clk by a programmable integer with glitch-free, runt-free divisor and enable changes.
//  All outputs are registered and toggle only on i_clk rising edges.
// PARAMETERS
//  NUM_CH   8    channel count; fixed at 8 to match mux width
//  DIV_W    16   divisor width in bits
//  DIV_RST  2    divisor loaded into every channel at reset
// PORTS
//  i_clk       in   1          source clock; all logic on rising edge
//  i_rst_n     in   1          asynchronous active-low reset
//  i_en        in   8          per-channel run enable, level
//  i_cfg_vld   in   1          divisor write request
//  i_cfg_ch    in   3          target channel of write
//  i_cfg_div   in   DIV_W      new divisor N
//  o_cfg_rdy   out  1          write accepted when i_cfg_vld & o_cfg_rdy
//  i_sync      in   1          phase-realign pulse (used only with CLK_DIV_SYNC_EN)
//  o_clk_div   out  8          divided clocks to mux
//  o_busy      out  8          per-channel: 1 while in HIGH or LOW
// BEHAVIOUR
//  Reset: o_clk_div=0, o_busy=0, o_cfg_rdy=1, all channels OFF, active and shadow divisors=DIV_RST, pending=0.
//  Divisor: effective N = max(N,2). Period N cycles: high H=N>>1 cycles, low L=N-H cycles (odd N: low longer).
//  Per-channel FSM: OFF -> HIGH -> LOW -> HIGH ...; counter counts down phase length, reloads at phase change.
//   OFF: output 0. i_en[k]=1 sampled at edge t -> HIGH entered, output 1 from edge t (latency 1 cycle after assert).
//   HIGH: on count expiry -> LOW. LOW: on expiry -> HIGH if en, else OFF.
//   i_en[k] drop in HIGH: complete high phase and the full low phase, then OFF (no runt pulses).
//   i_en[k] drop in LOW: finish low phase, then OFF. Re-assert before OFF reached: continues normally.
//  Config handshake: o_cfg_rdy = ~pending[i_cfg_ch] (combinational on i_cfg_ch).
//   Accepted write stores i_cfg_div in channel shadow, sets pending.
//   Pending applied at next LOW->HIGH boundary (period edge) or immediately if channel OFF; pending clears same edge.
//   Write to channel with pending=0 while another channel pending: accepted (rdy is per-channel).
//   Simultaneous accept and apply on same channel cannot occur (rdy=0 while pending).
//  o_busy[k]=1 in HIGH/LOW, 0 in OFF; registered with state.
//  Reset mid-operation: all outputs drop to reset values asynchronously; divisors return to DIV_RST (writes lost).
// CONFIGURATION
//  CLK_DIV_SYNC_EN defined: i_sync=1 at edge t forces every enabled channel to HIGH with fresh count, applying
//   any pending divisor, so all enabled outputs rise together at edge t. Disabled channels unaffected.
//   i_sync takes priority over normal FSM transitions and enable-drop sequencing for enabled channels.
//  CLK_DIV_SYNC_EN undefined: i_sync ignored (port kept, unused); channels free-run independently.
// STRUCTURE
//  Package clk_div_pkg: NUM_CH, DIV_W default, state encodings ST_OFF/ST_HIGH/ST_LOW, function
//   for clamp and H/L split.
//  Sub-module clk_div_chan (one channel: FSM, counter, shadow/pending, enable sequencing), instantiated
//   8x via generate; top holds config decode, rdy mux, output concatenation.
// TESTING
//  Reset, en=8'hFF, defaults -> all o_clk_div toggle every cycle (period 2), in phase, o_busy=8'hFF.
//  Write ch3 N=5, en[3]=1 -> o_clk_div[3] high 2 cycles, low 3 cycles, repeating; N=0 or 1 -> period 2.
//  Write ch1 N=8 mid-high of N=4 run -> current period completes at 4, next periods 4 high/4 low;
//   second write to ch1 before boundary sees o_cfg_rdy=0, is not accepted.
//  Drop en[2] one cycle into high phase of N=6 -> 3 high + 3 low complete, then 0, o_busy[2]=0.
//  With CLK_DIV_SYNC_EN: ch0 N=3, ch5 N=7 free-running, pulse i_sync -> both rise on the same edge;
//   without macro same stimulus -> no phase change.
//  Assert i_rst_n=0 mid-LOW with pending write -> outputs 0 immediately, rdy=1, divisor reverts to 2.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared constants, channel state encoding and divisor arithmetic for the clock divider bank.
package clk_div_pkg;

  localparam int NUM_CH = 8;
  localparam int CH_W   = 3;
  localparam int DIV_W  = 16;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } chan_state_e;

  // Divisors below 2 cannot form a high and a low phase, so they run as 2.
  function automatic logic [DIV_W-1:0] div_clamp(input logic [DIV_W-1:0] n);
    if (n < 16'd2) begin
      div_clamp = 16'd2;
    end else begin
      div_clamp = n;
    end
  endfunction

  function automatic logic [DIV_W-1:0] div_high(input logic [DIV_W-1:0] n);
    logic [DIV_W-1:0] c;
    c        = div_clamp(n);
    div_high = {1'b0, c[DIV_W-1:1]};
  endfunction

  // Odd divisors put the extra cycle in the low phase.
  function automatic logic [DIV_W-1:0] div_low(input logic [DIV_W-1:0] n);
    div_low = div_clamp(n) - div_high(n);
  endfunction

endpackage

// File: rtl/clk_div_bank_if.sv
// Divisor configuration handshake between a register master and the clock divider bank.
interface clk_div_bank_if;

  logic                          i_cfg_vld;
  logic [clk_div_pkg::CH_W-1:0]  i_cfg_ch;
  logic [clk_div_pkg::DIV_W-1:0] i_cfg_div;
  logic                          o_cfg_rdy;

  modport master (
    output i_cfg_vld,
    output i_cfg_ch,
    output i_cfg_div,
    input  o_cfg_rdy
  );

  modport slave (
    input  i_cfg_vld,
    input  i_cfg_ch,
    input  i_cfg_div,
    output o_cfg_rdy
  );

endinterface

// File: rtl/clk_div_chan.sv
// One divider channel: OFF/HIGH/LOW FSM, phase counter, shadow divisor and enable sequencing.
// Build option CLK_DIV_SYNC_EN adds the i_sync phase-realign path.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter logic [DIV_W-1:0] DIV_RST = 16'd2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_sync,
  input  logic             i_wr,
  input  logic [DIV_W-1:0] i_wr_div,
  output logic             o_clk,
  output logic             o_busy,
  output logic             o_pending
);

  chan_state_e      r_state;
  chan_state_e      w_state_nxt;
  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] w_cnt_nxt;
  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] w_div_nxt;
  logic [DIV_W-1:0] r_shadow;
  logic [DIV_W-1:0] w_shadow_nxt;
  logic [DIV_W-1:0] w_div_new;
  logic             r_pending;
  logic             w_pending_nxt;
  logic             r_clk;
  logic             r_busy;
  logic             w_sync;
  logic             w_cnt_zero;

`ifdef CLK_DIV_SYNC_EN
  assign w_sync = i_sync & i_en;
`else
  logic w_unused_sync;
  assign w_unused_sync = i_sync;
  assign w_sync        = 1'b0;
`endif

  // A fresh period always starts from the pending divisor if one is waiting.
  assign w_div_new  = r_pending ? r_shadow : r_div;
  assign w_cnt_zero = (r_cnt == {DIV_W{1'b0}});

  // Next-state, counter reload and divisor hand-over.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_div_nxt     = r_div;
    w_shadow_nxt  = r_shadow;
    w_pending_nxt = r_pending;
    if (w_sync) begin
      w_state_nxt   = ST_HIGH;
      w_cnt_nxt     = div_high(w_div_new) - DIV_W'(1);
      w_div_nxt     = w_div_new;
      w_pending_nxt = 1'b0;
    end else begin
      case (r_state)
        ST_OFF: begin
          w_div_nxt     = w_div_new;
          w_pending_nxt = 1'b0;
          if (i_en) begin
            w_state_nxt = ST_HIGH;
            w_cnt_nxt   = div_high(w_div_new) - DIV_W'(1);
          end else begin
            w_state_nxt = ST_OFF;
            w_cnt_nxt   = {DIV_W{1'b0}};
          end
        end
        ST_HIGH: begin
          if (w_cnt_zero) begin
            w_state_nxt = ST_LOW;
            w_cnt_nxt   = div_low(r_div) - DIV_W'(1);
          end else begin
            w_cnt_nxt   = r_cnt - DIV_W'(1);
          end
        end
        ST_LOW: begin
          if (!w_cnt_zero) begin
            w_cnt_nxt = r_cnt - DIV_W'(1);
          end else if (i_en) begin
            w_state_nxt   = ST_HIGH;
            w_cnt_nxt     = div_high(w_div_new) - DIV_W'(1);
            w_div_nxt     = w_div_new;
            w_pending_nxt = 1'b0;
          end else begin
            w_state_nxt = ST_OFF;
            w_cnt_nxt   = {DIV_W{1'b0}};
          end
        end
        default: begin
          w_state_nxt = ST_OFF;
          w_cnt_nxt   = {DIV_W{1'b0}};
        end
      endcase
    end
    // Writes only arrive while nothing is pending, so they never collide with an apply.
    if (i_wr) begin
      w_shadow_nxt  = i_wr_div;
      w_pending_nxt = 1'b1;
    end else begin
      w_shadow_nxt  = w_shadow_nxt;
    end
  end

  // Channel state and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_OFF;
      r_cnt     <= {DIV_W{1'b0}};
      r_div     <= DIV_RST;
      r_shadow  <= DIV_RST;
      r_pending <= 1'b0;
      r_clk     <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_div     <= w_div_nxt;
      r_shadow  <= w_shadow_nxt;
      r_pending <= w_pending_nxt;
      r_clk     <= (w_state_nxt == ST_HIGH);
      r_busy    <= (w_state_nxt != ST_OFF);
    end
  end

  assign o_clk     = r_clk;
  assign o_busy    = r_busy;
  assign o_pending = r_pending;

endmodule

// File: rtl/clk_div_bank.sv
// Bank of 8 programmable glitch-free clock dividers feeding the 8:1 clock select mux.
// Build option CLK_DIV_SYNC_EN enables the i_sync phase-realign pulse.
module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter int unsigned DIV_RST = 32'd2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [NUM_CH-1:0] i_en,
  clk_div_bank_if.slave     cfg_if,
  input  logic              i_sync,
  output logic [NUM_CH-1:0] o_clk_div,
  output logic [NUM_CH-1:0] o_busy
);

  logic [NUM_CH-1:0] w_pending;
  logic [NUM_CH-1:0] w_wr;
  logic              w_accept;

  // Ready is per channel: a busy shadow on one channel never stalls writes to another.
  assign cfg_if.o_cfg_rdy = ~w_pending[cfg_if.i_cfg_ch];
  assign w_accept         = cfg_if.i_cfg_vld & ~w_pending[cfg_if.i_cfg_ch];

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    assign w_wr[k] = w_accept & (cfg_if.i_cfg_ch == CH_W'(k));

    clk_div_chan #(
      .DIV_RST (DIV_W'(DIV_RST))
    ) u_chan (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_en      (i_en[k]),
      .i_sync    (i_sync),
      .i_wr      (w_wr[k]),
      .i_wr_div  (cfg_if.i_cfg_div),
      .o_clk     (o_clk_div[k]),
      .o_busy    (o_busy[k]),
      .o_pending (w_pending[k])
    );
  end

endmodule

// File: tb/tb_clk_div_bank.sv
// Self-checking bench for clk_div_bank: period-position model plus directed waveform pins.
`timescale 1ns/1ps
module tb_clk_div_bank;

`ifdef CLK_DIV_SYNC_EN
  localparam bit SYNC_ON = 1'b1;
`else
  localparam bit SYNC_ON = 1'b0;
`endif

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] en    = 8'h00;
  logic       sync  = 1'b0;
  logic [7:0] clk_div;
  logic [7:0] busy;

  clk_div_bank_if cfg_if();

  clk_div_bank #(.DIV_RST(2)) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_en      (en),
    .cfg_if    (cfg_if),
    .i_sync    (sync),
    .o_clk_div (clk_div),
    .o_busy    (busy)
  );

  always #5 clk = ~clk;

  // Model: each running channel is a position inside its current period.
  int          m_pos  [8];
  bit          m_on   [8];
  int          m_div  [8];
  int          m_sh   [8];
  bit          m_pend [8];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cap_ch  = 0;
  logic [31:0] cap     = 32'd0;

  function automatic int eff(input int n);
    return (n < 2) ? 2 : n;
  endfunction

  function automatic logic [7:0] exp_clk();
    logic [7:0] v;
    for (int k = 0; k < 8; k++) v[k] = m_on[k] && (m_pos[k] < eff(m_div[k]) / 2);
    return v;
  endfunction

  function automatic logic [7:0] exp_busy();
    logic [7:0] v;
    for (int k = 0; k < 8; k++) v[k] = m_on[k];
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 8; k++) begin
      m_pos[k] = 0; m_on[k] = 1'b0; m_div[k] = 2; m_sh[k] = 2; m_pend[k] = 1'b0;
    end
  endtask

  task automatic apply(input int k);
    if (m_pend[k]) begin
      m_div[k]  = m_sh[k];
      m_pend[k] = 1'b0;
    end
  endtask

  task automatic model_step();
    int c;
    bit acc;
    c   = int'(cfg_if.i_cfg_ch);
    acc = cfg_if.i_cfg_vld && !m_pend[c];
    for (int k = 0; k < 8; k++) begin
      if (SYNC_ON && sync && en[k]) begin
        apply(k); m_on[k] = 1'b1; m_pos[k] = 0;
      end else if (!m_on[k]) begin
        apply(k);
        if (en[k]) begin m_on[k] = 1'b1; m_pos[k] = 0; end
      end else begin
        m_pos[k]++;
        if (m_pos[k] >= eff(m_div[k])) begin
          if (en[k]) begin apply(k); m_pos[k] = 0; end
          else begin m_on[k] = 1'b0; m_pos[k] = 0; end
        end
      end
    end
    if (acc) begin
      m_sh[c]   = int'(cfg_if.i_cfg_div);
      m_pend[c] = 1'b1;
    end
  endtask

  // One clock cycle: ready check before the edge, model step at the edge, output check after it.
  task automatic tick();
    #2;
    check("cfg_rdy", 32'(cfg_if.o_cfg_rdy), 32'(!m_pend[int'(cfg_if.i_cfg_ch)]));
    @(posedge clk);
    model_step();
    #1;
    check("clk_div", 32'(clk_div), 32'(exp_clk()));
    check("busy", 32'(busy), 32'(exp_busy()));
    cap = {cap[30:0], clk_div[cap_ch]};
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wr(input int ch, input int div);
    cfg_if.i_cfg_vld = 1'b1;
    cfg_if.i_cfg_ch  = 3'(ch);
    cfg_if.i_cfg_div = 16'(div);
    tick();
    cfg_if.i_cfg_vld = 1'b0;
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_clk_div", 32'(clk_div), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_rdy", 32'(cfg_if.o_cfg_rdy), 32'h1);
    en = 8'h00; sync = 1'b0; cfg_if.i_cfg_vld = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    cfg_if.i_cfg_vld = 1'b0;
    cfg_if.i_cfg_ch  = 3'd0;
    cfg_if.i_cfg_div = 16'd0;
    model_reset();

    // Default divisor 2 on every channel: in-phase toggling.
    do_reset();
    en = 8'hFF; cap_ch = 0; cap = 32'd0;
    tick();
    check("all_first_high", 32'(clk_div), 32'hFF);
    check("all_busy", 32'(busy), 32'hFF);
    tick();
    check("all_first_low", 32'(clk_div), 32'h00);
    ticks(4);
    check("all_toggle", cap & 32'h3F, 32'b101010);

    // Channel 3: N=5, then N=0 and N=1 fall back to period 2.
    do_reset();
    wr(3, 5);
    en = 8'h08; cap_ch = 3; cap = 32'd0;
    ticks(10);
    check("ch3_n5_wave", cap & 32'h3FF, 32'b1100011000);
    en = 8'h00;
    ticks(6);
    check("ch3_off_busy", 32'(busy[3]), 32'h0);
    wr(3, 0);
    en = 8'h08; cap = 32'd0;
    ticks(6);
    check("ch3_n0_wave", cap & 32'h3F, 32'b101010);
    en = 8'h00;
    ticks(3);
    wr(3, 1);
    en = 8'h08; cap = 32'd0;
    ticks(6);
    check("ch3_n1_wave", cap & 32'h3F, 32'b101010);

    // Channel 1: N=4 run, N=8 written mid-high, second write blocked until the boundary.
    do_reset();
    wr(1, 4);
    en = 8'h02; cap_ch = 1; cap = 32'd0;
    tick();
    wr(1, 8);
    cfg_if.i_cfg_vld = 1'b1; cfg_if.i_cfg_ch = 3'd1; cfg_if.i_cfg_div = 16'd3;
    tick();
    check("ch1_rdy_blocked", 32'(cfg_if.o_cfg_rdy), 32'h0);
    cfg_if.i_cfg_vld = 1'b0;
    ticks(2);
    check("ch1_rdy_after_apply", 32'(cfg_if.o_cfg_rdy), 32'h1);
    ticks(11);
    check("ch1_retime_wave", cap & 32'hFFFF, 32'hCF0F);

    // Channel 2: N=6, enable dropped one cycle into the high phase.
    do_reset();
    wr(2, 6);
    en = 8'h04; cap_ch = 2; cap = 32'd0;
    tick();
    en = 8'h00;
    ticks(7);
    check("ch2_drop_wave", cap & 32'hFF, 32'b11100000);
    check("ch2_drop_busy", 32'(busy[2]), 32'h0);

    // Channels 0 (N=3) and 5 (N=7): i_sync realigns only when the feature is built in.
    do_reset();
    wr(0, 3);
    wr(5, 7);
    en = 8'h21;
    ticks(5);
    sync = 1'b1;
    tick();
    sync = 1'b0;
    check("sync_align", {30'd0, clk_div[5], clk_div[0]}, SYNC_ON ? 32'h3 : 32'h0);
    ticks(8);

    // Reset while channel 3 is low with a divisor write pending.
    do_reset();
    en = 8'h08; cap_ch = 3;
    tick();
    wr(3, 9);
    check("ch3_pending_busy", 32'(busy[3]), 32'h1);
    do_reset();
    en = 8'h08; cap = 32'd0;
    ticks(4);
    check("ch3_div_reverted", cap & 32'hF, 32'b1010);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
